// File: rtl/arbitro_memoria.sv
// Round-robin arbiter sharing one 512x12 single-port RAM between two requesters.
// Owns the RAM address/data/write-enable pins; every output is registered.
module arbitro_memoria #(
  parameter int ANCHO_DIR         = 9,
  parameter int ANCHO_DATO        = 12,
  parameter int PRIORIDAD_INICIAL = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  sol_a,
  input  logic                  esc_a,
  input  logic [ANCHO_DIR-1:0]  dir_a,
  input  logic [ANCHO_DATO-1:0] dato_a,
  output logic                  ack_a,
  output logic [ANCHO_DATO-1:0] dato_leido_a,
  input  logic                  sol_b,
  input  logic                  esc_b,
  input  logic [ANCHO_DIR-1:0]  dir_b,
  input  logic [ANCHO_DATO-1:0] dato_b,
  output logic                  ack_b,
  output logic [ANCHO_DATO-1:0] dato_leido_b,
  output logic                  mem_we,
  output logic [ANCHO_DIR-1:0]  mem_dir,
  output logic [ANCHO_DATO-1:0] mem_din,
  input  logic [ANCHO_DATO-1:0] mem_dout,
  output logic                  ocupado
);

  localparam logic [1:0] INACTIVO = 2'd0;
  localparam logic [1:0] ACCESO   = 2'd1;
  localparam logic [1:0] LECTURA  = 2'd2;
  localparam logic [1:0] FIN      = 2'd3;

  localparam logic PUNTERO_RST = (PRIORIDAD_INICIAL != 0);

  logic [1:0]            estado_q, estado_d;
  logic                  puntero_q, puntero_d;
  logic                  ganador_q, ganador_d;
  logic                  mem_we_q, mem_we_d;
  logic [ANCHO_DIR-1:0]  mem_dir_q, mem_dir_d;
  logic [ANCHO_DATO-1:0] mem_din_q, mem_din_d;
  logic                  ack_a_q, ack_a_d;
  logic                  ack_b_q, ack_b_d;
  logic [ANCHO_DATO-1:0] leido_a_q, leido_a_d;
  logic [ANCHO_DATO-1:0] leido_b_q, leido_b_d;
  logic                  ocupado_q, ocupado_d;

  logic                  hay_sol;
  logic                  gana_b;

  assign hay_sol = sol_a | sol_b;

  // gana_b: B wins when alone, or when both ask and the pointer favours B
  always_comb begin
    gana_b = 1'b0;
    unique case (1'b1)
      (sol_a && !sol_b): gana_b = 1'b0;
      (!sol_a && sol_b): gana_b = 1'b1;
      (sol_a && sol_b):  gana_b = puntero_q;
      default:           gana_b = 1'b0;
    endcase
  end

  always_comb begin
    estado_d  = estado_q;
    puntero_d = puntero_q;
    ganador_d = ganador_q;
    mem_we_d  = mem_we_q;
    mem_dir_d = mem_dir_q;
    mem_din_d = mem_din_q;
    ack_a_d   = 1'b0;
    ack_b_d   = 1'b0;
    leido_a_d = leido_a_q;
    leido_b_d = leido_b_q;
    unique case (estado_q)
      INACTIVO: begin
        if (hay_sol) begin
          ganador_d = gana_b;
          puntero_d = ~gana_b;
          mem_we_d  = gana_b ? esc_b  : esc_a;
          mem_dir_d = gana_b ? dir_b  : dir_a;
          mem_din_d = gana_b ? dato_b : dato_a;
          estado_d  = ACCESO;
        end
      end
      ACCESO: begin
        mem_we_d = 1'b0;
        // mem_we_q still carries the latched operation here
        if (mem_we_q) begin
          ack_a_d  = ~ganador_q;
          ack_b_d  = ganador_q;
          estado_d = FIN;
        end else begin
          estado_d = LECTURA;
        end
      end
      LECTURA: begin
        if (ganador_q) leido_b_d = mem_dout;
        else           leido_a_d = mem_dout;
        ack_a_d  = ~ganador_q;
        ack_b_d  = ganador_q;
        estado_d = FIN;
      end
      FIN: begin
        estado_d = INACTIVO;
      end
      default: begin
        estado_d = INACTIVO;
      end
    endcase
    ocupado_d = (estado_d != INACTIVO);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q  <= INACTIVO;
      puntero_q <= PUNTERO_RST;
      ganador_q <= 1'b0;
      mem_we_q  <= 1'b0;
      mem_dir_q <= '0;
      mem_din_q <= '0;
      ack_a_q   <= 1'b0;
      ack_b_q   <= 1'b0;
      leido_a_q <= '0;
      leido_b_q <= '0;
      ocupado_q <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      puntero_q <= puntero_d;
      ganador_q <= ganador_d;
      mem_we_q  <= mem_we_d;
      mem_dir_q <= mem_dir_d;
      mem_din_q <= mem_din_d;
      ack_a_q   <= ack_a_d;
      ack_b_q   <= ack_b_d;
      leido_a_q <= leido_a_d;
      leido_b_q <= leido_b_d;
      ocupado_q <= ocupado_d;
    end
  end

  assign mem_we       = mem_we_q;
  assign mem_dir      = mem_dir_q;
  assign mem_din      = mem_din_q;
  assign ack_a        = ack_a_q;
  assign ack_b        = ack_b_q;
  assign dato_leido_a = leido_a_q;
  assign dato_leido_b = leido_b_q;
  assign ocupado      = ocupado_q;

endmodule
